// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Purpose  : Iterative unsigned restoring divider. A WIDTH-bit dividend is
//            divided by a WIDTH-bit divisor with one subtract-and-shift step
//            per clock, under a start/busy/done handshake.
//            Divide-by-zero finishes in one cycle with quotient = all ones,
//            remainder = dividend and div_by_zero = 1.
// Ports    : clk          rising-edge clock
//            rst_n        asynchronous active-low reset
//            start        request, sampled only when not busy
//            dividend     numerator, captured on accepted start
//            divisor      denominator, captured on accepted start
//            busy         high while a division is in flight
//            done         one-cycle pulse, results valid from this cycle on
//            quotient     result, held until the next accepted start
//            remainder    result, held until the next accepted start
//            div_by_zero  set with done when the captured divisor was 0
//            check_err    (only with DIV_SELFCHECK_EN) result identity check
// Options  : DIV_SELFCHECK_EN -- adds check_err, which is set on the done
//            edge when quotient*divisor+remainder != dividend.
// Revision : 1.0 - initial release
// ============================================================================
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
`ifdef DIV_SELFCHECK_EN
  ,
  output logic             check_err
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] divisor_r;
  logic [WIDTH-1:0] q_tmp;     // dividend bits shift out the top, quotient bits in at the bottom
  logic [WIDTH-1:0] rem_tmp;   // partial remainder, always < divisor between steps
  logic [CW-1:0]    count;

  // One restoring step. The shifted remainder needs WIDTH+1 bits so the
  // compare against the divisor cannot overflow. The compare is taken from
  // the borrow of the subtraction: since the shifted value is below
  // 2*divisor, bit WIDTH of the difference is 0 exactly when it fits.
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   diff;
  logic             fits;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] q_next;

  always_comb begin
    rem_shift = {rem_tmp, q_tmp[WIDTH-1]};
    diff      = rem_shift - {1'b0, divisor_r};
    fits      = ~diff[WIDTH];
    rem_next  = fits ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    q_next    = {q_tmp[WIDTH-2:0], fits};
  end

`ifdef DIV_SELFCHECK_EN
  logic [WIDTH-1:0]   dividend_r;
  logic [2*WIDTH-1:0] recon;

  // Reconstruct the dividend from the final-step results in full 2*WIDTH math.
  always_comb begin
    recon = ({{WIDTH{1'b0}}, q_next} * {{WIDTH{1'b0}}, divisor_r})
          + {{WIDTH{1'b0}}, rem_next};
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      divisor_r   <= '0;
      q_tmp       <= '0;
      rem_tmp     <= '0;
      count       <= '0;
`ifdef DIV_SELFCHECK_EN
      dividend_r  <= '0;
      check_err   <= 1'b0;
`endif
    end else begin
      case (state)
        // DONE accepts a new start exactly like IDLE so back-to-back
        // divisions run without a bubble cycle.
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            if (divisor != '0) begin
              state       <= RUN;
              busy        <= 1'b1;
              div_by_zero <= 1'b0;
              divisor_r   <= divisor;
              q_tmp       <= dividend;
              rem_tmp     <= '0;
              count       <= '0;
`ifdef DIV_SELFCHECK_EN
              dividend_r  <= dividend;
`endif
            end else begin
              // Divide-by-zero short-cuts straight to DONE, no RUN cycles.
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
`ifdef DIV_SELFCHECK_EN
              check_err   <= 1'b0;
`endif
            end
          end else begin
            state <= IDLE;
          end
        end

        RUN: begin
          rem_tmp <= rem_next;
          q_tmp   <= q_next;
          count   <= count + CW'(1);
          if (count == LAST_STEP) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= q_next;
            remainder <= rem_next;
`ifdef DIV_SELFCHECK_EN
            check_err <= (recon != {{WIDTH{1'b0}}, dividend_r});
`endif
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
